// File: rtl/jtag_serializer.sv
// jtag_serializer: parallel config words in over valid/ready, one frame bit per cycle out to jtag2 tile 0.
// Define JTAG_SER_LSB_FIRST_EN to shift each word LSB first; default build shifts MSB first.
module jtag_serializer #(
  parameter int WORD_W       = 16,
  parameter int NUM_OF_TILES = 4,
  parameter int MEM_CYCLES   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done
);
  localparam int TOTAL_BITS  = NUM_OF_TILES * MEM_CYCLES;
  localparam int TOTAL_WORDS = TOTAL_BITS / WORD_W;
  localparam int BC_W        = $clog2(WORD_W);
  localparam int WC_W        = $clog2(TOTAL_WORDS + 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0] WORD_ALL = WC_W'(TOTAL_WORDS);

  if (TOTAL_BITS % WORD_W != 0) begin : g_bad_frame
    $error("jtag_serializer: NUM_OF_TILES*MEM_CYCLES must be a multiple of WORD_W");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic [WORD_W-1:0] sreg_q;
  logic [WORD_W-1:0] sreg_d;
  logic              loaded_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic              data_out_q;
  logic              data_valid_q;
  logic              done_q;
  logic              last_bit;
  logic              xfer;
  logic              cur_bit;

  assign last_bit = (bit_cnt_q == BIT_LAST);
  // Refill is offered either when empty or exactly on the final bit, so a held in_valid yields a gapless stream.
  assign in_ready = (state_q == SHIFT) && (!loaded_q || (last_bit && (word_cnt_q < WORD_ALL)));
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

`ifdef JTAG_SER_LSB_FIRST_EN
  assign cur_bit = sreg_q[0];
  assign sreg_d  = sreg_q >> 1;
`else
  assign cur_bit = sreg_q[WORD_W-1];
  assign sreg_d  = sreg_q << 1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      loaded_q     <= 1'b0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      data_out_q   <= 1'b0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          data_valid_q <= 1'b0;
          done_q       <= 1'b0;
          if (start) begin
            state_q    <= SHIFT;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            loaded_q   <= 1'b0;
          end
        end
        SHIFT: begin
          data_valid_q <= loaded_q;
          if (loaded_q) begin
            data_out_q <= cur_bit;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= last_bit ? '0 : bit_cnt_q + BC_W'(1);
            if (last_bit && !xfer) begin
              loaded_q <= 1'b0;
              if (word_cnt_q == WORD_ALL) state_q <= DONE;
            end
          end
          if (xfer) begin
            sreg_q     <= in_data;
            loaded_q   <= 1'b1;
            word_cnt_q <= word_cnt_q + WC_W'(1);
          end
        end
        DONE: begin
          // First DONE cycle lands the last bit's valid drop; the second carries done while still busy.
          data_valid_q <= 1'b0;
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
endmodule

// File: tb/tb_jtag_serializer.sv
// Bench for jtag_serializer with 8-bit words, 2 tiles x 16 bits (4 words / 32 bits per frame).
module tb_jtag_serializer;
  localparam int WORD_W      = 8;
  localparam int TOTAL_BITS  = 32;
  localparam int TOTAL_WORDS = 4;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, data_out, data_valid, busy, done;
  logic [WORD_W-1:0] in_data;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  jtag_serializer #(.WORD_W(WORD_W), .NUM_OF_TILES(2), .MEM_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done)
  );

  int   cyc = 0;
  bit   mon_en = 0;
  int   xfer_cnt, done_cnt, first_xfer, first_v, last_v, done_cyc, start_cyc;
  logic busy_at_done, busy_after;
  bit   q_bits[$];
  bit   exp_bits[$];
  logic [WORD_W-1:0] wq[$];

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (start && !busy && start_cyc < 0) start_cyc = cyc;
      if (in_valid && in_ready) begin
        xfer_cnt++;
        if (first_xfer < 0) first_xfer = cyc;
      end
      if (data_valid) begin
        q_bits.push_back(data_out);
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
    end
  end

  // Reference: the frame is the first n accepted words, each serialized in the build's bit order.
  function automatic void build_exp(input int n);
    exp_bits.delete();
    for (int w = 0; w < n && w < wq.size(); w++)
      for (int b = 0; b < WORD_W; b++)
`ifdef JTAG_SER_LSB_FIRST_EN
        exp_bits.push_back(wq[w][b]);
`else
        exp_bits.push_back(wq[w][WORD_W-1-b]);
`endif
  endfunction

  function automatic int bit_errors();
    int e = 0;
    for (int i = 0; i < TOTAL_BITS; i++)
      if (i >= q_bits.size() || i >= exp_bits.size() || q_bits[i] !== exp_bits[i]) e++;
    return e;
  endfunction

  function automatic void rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back(WORD_W'($urandom));
  endfunction

  // status: 0 = frame completed, 1 = stopped for reset, 2 = cycle budget expired
  task automatic run_frame(input int gap_idx, input int gap_len, input int start_bit,
                           input int rst_bit, output int status);
    int gl = gap_len;
    bit pulsed = 0;
    status = 2;
    xfer_cnt = 0; done_cnt = 0; first_xfer = -1; first_v = -1; last_v = -1;
    done_cyc = -1; start_cyc = -1; busy_at_done = 1'bx; busy_after = 1'bx;
    q_bits.delete();
    mon_en = 1;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (rst_bit >= 0 && q_bits.size() >= rst_bit) begin status = 1; break; end
      if (done_cnt > 0 && cyc >= done_cyc + 2) begin status = 0; break; end
      start = (start_bit >= 0 && !pulsed && q_bits.size() >= start_bit);
      if (start) pulsed = 1;
      if (xfer_cnt == gap_idx && gl > 0) begin
        in_valid = 1'b0;
        if (in_ready) gl--;
      end else begin
        in_valid = (xfer_cnt < wq.size());
      end
      in_data = (xfer_cnt < wq.size()) ? wq[xfer_cnt] : WORD_W'($urandom);
    end
    start = 1'b0; in_valid = 1'b0;
    mon_en = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    checks++;
    if ({in_ready, data_out, data_valid, busy, done} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {in_ready, data_out, data_valid, busy, done});
    else passes++;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy} !== 2'b0) $display("FAIL idle_after_reset: got %b want 00", {in_ready, busy});
    else passes++;
  endtask

  task automatic test_continuous();
    int st;
    wq.delete();
    wq.push_back(8'hA5); wq.push_back(8'h3C); wq.push_back(8'hFF); wq.push_back(8'h00);
    build_exp(TOTAL_WORDS);
    run_frame(-1, 0, -1, -1, st);
    checks++; if (st !== 0) $display("FAIL cont_status: got %0d want 0", st); else passes++;
    checks++; if (q_bits.size() !== TOTAL_BITS) $display("FAIL cont_nbits: got %0d want %0d", q_bits.size(), TOTAL_BITS); else passes++;
    checks++; if (bit_errors() !== 0) $display("FAIL cont_bits: got %0d bad bits want 0", bit_errors()); else passes++;
    checks++; if (last_v - first_v + 1 !== TOTAL_BITS) $display("FAIL cont_span: got %0d want %0d", last_v - first_v + 1, TOTAL_BITS); else passes++;
    checks++; if (first_xfer !== start_cyc + 1) $display("FAIL first_accept: got cycle %0d want %0d", first_xfer, start_cyc + 1); else passes++;
    checks++; if (first_v !== first_xfer + 2) $display("FAIL first_bit_latency: got cycle %0d want %0d", first_v, first_xfer + 2); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL cont_done_cnt: got %0d want 1", done_cnt); else passes++;
    checks++; if (done_cyc !== last_v + 1) $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_v + 1); else passes++;
    checks++; if (busy_at_done !== 1'b1) $display("FAIL busy_at_done: got %b want 1", busy_at_done); else passes++;
    checks++; if (busy_after !== 1'b0) $display("FAIL busy_after_done: got %b want 0", busy_after); else passes++;
  endtask

  task automatic test_gapped();
    int st;
    wq.delete();
    wq.push_back(8'hA5); wq.push_back(8'h3C); wq.push_back(8'hFF); wq.push_back(8'h00);
    build_exp(TOTAL_WORDS);
    run_frame(2, 3, -1, -1, st);
    checks++; if (st !== 0) $display("FAIL gap_status: got %0d want 0", st); else passes++;
    checks++; if (q_bits.size() !== TOTAL_BITS) $display("FAIL gap_nbits: got %0d want %0d", q_bits.size(), TOTAL_BITS); else passes++;
    checks++; if (bit_errors() !== 0) $display("FAIL gap_bits: got %0d bad bits want 0", bit_errors()); else passes++;
    checks++; if (last_v - first_v + 1 !== TOTAL_BITS + 3) $display("FAIL gap_span: got %0d want %0d", last_v - first_v + 1, TOTAL_BITS + 3); else passes++;
  endtask

  task automatic test_overrun();
    int st;
    rand_words(6);
    build_exp(TOTAL_WORDS);
    run_frame(-1, 0, -1, -1, st);
    checks++; if (xfer_cnt !== TOTAL_WORDS) $display("FAIL overrun_xfers: got %0d want %0d", xfer_cnt, TOTAL_WORDS); else passes++;
    checks++; if (q_bits.size() !== TOTAL_BITS) $display("FAIL overrun_nbits: got %0d want %0d", q_bits.size(), TOTAL_BITS); else passes++;
    checks++; if (bit_errors() !== 0) $display("FAIL overrun_bits: got %0d bad bits want 0", bit_errors()); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL overrun_done_cnt: got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_reset_midframe();
    int st;
    rand_words(TOTAL_WORDS);
    run_frame(-1, 0, -1, 13, st);
    checks++; if (st !== 1) $display("FAIL midrst_reach: got status %0d want 1", st); else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, data_out, data_valid, busy, done} !== 5'b0)
      $display("FAIL midrst_outputs: got %b want 00000", {in_ready, data_out, data_valid, busy, done});
    else passes++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rand_words(TOTAL_WORDS);
    build_exp(TOTAL_WORDS);
    run_frame(-1, 0, -1, -1, st);
    checks++; if (st !== 0) $display("FAIL midrst_restart_status: got %0d want 0", st); else passes++;
    checks++; if (q_bits.size() !== TOTAL_BITS) $display("FAIL midrst_nbits: got %0d want %0d", q_bits.size(), TOTAL_BITS); else passes++;
    checks++; if (bit_errors() !== 0) $display("FAIL midrst_bits: got %0d bad bits want 0", bit_errors()); else passes++;
  endtask

  task automatic test_ignored_start();
    int st;
    rand_words(TOTAL_WORDS);
    build_exp(TOTAL_WORDS);
    run_frame(-1, 0, 10, -1, st);
    checks++; if (st !== 0) $display("FAIL istart_status: got %0d want 0", st); else passes++;
    checks++; if (done_cnt !== 1) $display("FAIL istart_done_cnt: got %0d want 1", done_cnt); else passes++;
    checks++; if (bit_errors() !== 0) $display("FAIL istart_bits: got %0d bad bits want 0", bit_errors()); else passes++;
    checks++; if (last_v - first_v + 1 !== TOTAL_BITS) $display("FAIL istart_span: got %0d want %0d", last_v - first_v + 1, TOTAL_BITS); else passes++;
  endtask

  task automatic test_random_frames();
    int st, gi, gl;
    for (int it = 0; it < 4; it++) begin
      rand_words(TOTAL_WORDS);
      build_exp(TOTAL_WORDS);
      gi = $urandom_range(1, 3);
      gl = $urandom_range(0, 4);
      run_frame(gi, gl, -1, -1, st);
      checks++; if (st !== 0) $display("FAIL rand%0d_status: got %0d want 0", it, st); else passes++;
      checks++; if (bit_errors() !== 0) $display("FAIL rand%0d_bits: got %0d bad bits want 0", it, bit_errors()); else passes++;
      checks++; if (q_bits.size() !== TOTAL_BITS) $display("FAIL rand%0d_nbits: got %0d want %0d", it, q_bits.size(), TOTAL_BITS); else passes++;
      checks++; if (last_v - first_v + 1 !== TOTAL_BITS + gl) $display("FAIL rand%0d_span: got %0d want %0d", it, last_v - first_v + 1, TOTAL_BITS + gl); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_overrun();
    test_reset_midframe();
    test_ignored_start();
    test_random_frames();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
